// File: rtl/instr_controller.sv
// Instruction controller: latches a 16-bit instruction and sequences the
// register-file and shift/ALU datapath controls for it, one instruction at a time.
module instr_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnumA,
  output logic [2:0]  readnumB,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  logic isMovImm;
  logic isMovReg;
  logic isAlu;
  logic isCmp;
  logic isMvn;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign isMovImm = (opcode == 3'b110) && (op == 2'b10);
  assign isMovReg = (opcode == 3'b110) && (op == 2'b00);
  assign isAlu    = (opcode == 3'b101);
  assign isCmp    = isAlu && (op == 2'b01);
  assign isMvn    = isAlu && (op == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // IR only updates in WAIT, so decode always sees the word present when s was accepted.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        if (load) ir_d = instr_in;
        if (s) begin
          state_d = S_DECODE;
          err_d   = 1'b0;
        end
      end
      S_DECODE: begin
        if (isMovImm)               state_d = S_WRITE_IMM;
        else if (isMovReg || isMvn) state_d = S_GET_B;
        else if (isAlu)             state_d = S_GET_A;
        else begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = isCmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  assign err      = err_q;
  assign readnumA = rn;
  assign readnumB = rm;
  assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign bsel     = 1'b0;

  // Moore outputs: decoded from state and IR only, so reset forces them at once.
  always_comb begin
    w        = 1'b0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    writenum = rd;
    case (state_q)
      S_WAIT:  w = 1'b1;
      S_GET_A: loada = 1'b1;
      S_GET_B: loadb = 1'b1;
      S_EXEC: begin
        shift = sh;
        asel  = isMovReg || isMvn;
        ALUop = isMovReg ? 2'b00 : op;
        loads = isCmp;
        loadc = !isCmp;
      end
      S_WRITE_REG: write = 1'b1;
      S_WRITE_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = rn;
      end
      default: ;
    endcase
  end

endmodule
